// File: rtl/alu_issue_ctrl.sv
// Issue controller for the datapath ALU: accepts one MIPS instruction, decodes it,
// registers the ALU operands, captures the result and hands it on to writeback.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic [15:0] retired
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpSrl = 3'd4;
  localparam logic [2:0] OpSra = 3'd5;
  localparam logic [2:0] OpNop = 3'd6;

  logic [1:0]  state_q, state_d;
  logic [31:0] alu_a_q, alu_b_q, result_q;
  logic [2:0]  alu_op_q;
  logic [4:0]  rd_q;
  logic        illegal_q, valid_q;
  logic [15:0] retired_q;

  logic [31:0] dec_a, dec_b;
  logic [2:0]  dec_op;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rt_field, rd_field;
  logic [15:0] imm;

  // The rs field is not decoded: its value arrives already fetched on rs_val.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign shamt    = instr[10:6];
  assign rd_field = instr[15:11];
  assign rt_field = instr[20:16];
  assign imm      = instr[15:0];

  always_comb begin
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_op      = OpNop;
    dec_rd      = 5'd0;
    dec_illegal = 1'b1;
    unique case (opcode)
      6'b000000: begin
        unique case (funct)
          6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
            dec_a       = rs_val;
            dec_b       = rt_val;
            dec_rd      = rd_field;
            dec_illegal = 1'b0;
            unique case (funct)
              6'b100001: dec_op = OpAdd;
              6'b100011: dec_op = OpSub;
              6'b100100: dec_op = OpAnd;
              default:   dec_op = OpOr;
            endcase
          end
          6'b000010, 6'b000011, 6'b000110, 6'b000111: begin
            dec_a       = rt_val;
            // funct[2] selects the variable-shift forms that take the amount from rs.
            dec_b       = funct[2] ? {27'd0, rs_val[4:0]} : {27'd0, shamt};
            dec_op      = funct[0] ? OpSra : OpSrl;
            dec_rd      = rd_field;
            dec_illegal = 1'b0;
          end
          default: ;
        endcase
      end
      6'b001001: begin
        dec_a       = rs_val;
        dec_b       = {{16{imm[15]}}, imm};
        dec_op      = OpAdd;
        dec_rd      = rt_field;
        dec_illegal = 1'b0;
      end
      6'b001100, 6'b001101: begin
        dec_a       = rs_val;
        dec_b       = {16'd0, imm};
        dec_op      = opcode[0] ? OpOr : OpAnd;
        dec_rd      = rt_field;
        dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_op_q  <= 3'd0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      result_q  <= 32'd0;
      valid_q   <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            alu_a_q   <= dec_a;
            alu_b_q   <= dec_b;
            alu_op_q  <= dec_op;
            rd_q      <= dec_rd;
            illegal_q <= dec_illegal;
          end
        end
        EXEC: begin
          result_q <= illegal_q ? 32'd0 : alu_c;
          valid_q  <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            valid_q   <= 1'b0;
            retired_q <= retired_q + 16'd1;
          end
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: models the ALU, predicts each result from the instruction
// semantics into a scoreboard queue and compares when the controller presents it.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, rs_val, rt_val;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] retired;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_retired = 16'd0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_c      (alu_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_illegal(out_illegal),
    .retired    (retired)
  );

  // Datapath ALU
  always_comb begin
    alu_c = 32'd0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = alu_a >> alu_b[4:0];
      3'd5: alu_c = $signed(alu_a) >>> alu_b[4:0];
      default: alu_c = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t e;
    logic [15:0] im;
    im    = ins[15:0];
    e.ill = 1'b0;
    e.rd  = ins[15:11];
    e.res = 32'd0;
    if (ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'h21: e.res = rs + rt;
        6'h23: e.res = rs - rt;
        6'h24: e.res = rs & rt;
        6'h25: e.res = rs | rt;
        6'h02: e.res = rt >> ins[10:6];
        6'h03: e.res = $signed(rt) >>> ins[10:6];
        6'h06: e.res = rt >> rs[4:0];
        6'h07: e.res = $signed(rt) >>> rs[4:0];
        default: begin e.ill = 1'b1; e.rd = 5'd0; end
      endcase
    end else begin
      e.rd = ins[20:16];
      case (ins[31:26])
        6'h09: e.res = rs + {{16{im[15]}}, im};
        6'h0C: e.res = rs & {16'd0, im};
        6'h0D: e.res = rs | {16'd0, im};
        default: begin e.ill = 1'b1; e.rd = 5'd0; end
      endcase
    end
    return e;
  endfunction

  task automatic run_txn(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input int hold);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    instr    = ins;
    rs_val   = rs;
    rt_val   = rt;
    in_valid = 1'b1;
    sb.push_back(model(ins, rs, rt));
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 32'hFFFF_FFFF;
    rs_val   = 32'h1234_5678;
    rt_val   = 32'h8765_4321;
    check("exec_out_valid", 32'(out_valid), 32'd0);
    check("exec_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("out_valid_e2", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("out_result", out_result, e.res);
    check("out_rd", 32'(out_rd), 32'(e.rd));
    check("out_illegal", 32'(out_illegal), 32'(e.ill));
    for (int i = 0; i < hold; i++) begin
      // A competing request during backpressure must be ignored.
      in_valid = 1'b1;
      instr    = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h21);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", out_result, e.res);
      check("hold_rd", 32'(out_rd), 32'(e.rd));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_retired = exp_retired + 16'd1;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("retired", 32'(retired), 32'(exp_retired));
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'd0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_illegal", 32'(out_illegal), 32'd0);

    // Spurious out_ready while idle must not retire anything.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready", 32'(retired), 32'd0);

    run_txn(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'hFFFF_FFFF, 32'd2, 0);
    run_txn(rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h03), 32'd0, 32'h8000_0000, 0);
    run_txn(rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h06), 32'h24, 32'h8000_0000, 0);
    run_txn(itype(6'h09, 5'd1, 5'd7, 16'hFFFF), 32'd5, 32'd0, 0);
    run_txn(itype(6'h0D, 5'd1, 5'd8, 16'h8000), 32'd0, 32'd0, 0);
    run_txn(itype(6'h3F, 5'd1, 5'd8, 16'h1234), 32'd7, 32'd9, 0);
    check("alu_op_illegal", 32'(alu_op), 32'd6);
    run_txn(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h23), 32'd3, 32'd5, 0);
    run_txn(rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h2A), 32'd3, 32'd5, 0);
    run_txn(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h24), 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_txn(rtype(5'd1, 5'd2, 5'd13, 5'd0, 6'h25), 32'hF000_0000, 32'h0000_000F, 10);
    run_txn(rtype(5'd1, 5'd2, 5'd14, 5'd8, 6'h02), 32'd0, 32'h8000_0000, 0);
    run_txn(rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h07), 32'h3F, 32'h8000_0000, 0);
    run_txn(itype(6'h0C, 5'd1, 5'd16, 16'h8F0F), 32'hFFFF_FFFF, 32'd0, 0);
    for (int i = 0; i < 6; i++)
      run_txn(itype(6'h09, 5'd1, 5'(17 + i), 16'($urandom)), $urandom, 32'd0, 0);

    // Jump the retire counter to its last value and wrap it.
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    run_txn(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd1, 32'd1, 0);
    check("retired_wrap", 32'(retired), 32'd0);

    // Reset while the instruction is executing abandons it.
    @(negedge clk);
    instr    = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    rs_val   = 32'd1;
    rt_val   = 32'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_exec", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_retired = 16'd0;
    for (int i = 0; i < 3; i++) begin
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_retired", 32'(retired), 32'(exp_retired));
      @(negedge clk);
    end
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_txn(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h21), 32'd10, 32'd20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
